// File: rtl/wb_exmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_exmem_ctrl
// Description : Wishbone slave to single-port BRAM bridge with programmable
//               wait states between request accept and the BRAM access.
//               Optional WB_EXMEM_ADDR_CHECK_EN: requests outside BASE_ADDR
//               window are acked immediately with zero data, no BRAM access.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_exmem_ctrl #(
    parameter int          DELAYS    = 10,
    parameter int          AW        = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          bram_en_o,
    output logic [3:0]    bram_we_o,
    output logic [AW-1:0] bram_adr_o,
    output logic [31:0]   bram_di_o,
    input  logic [31:0]   bram_do_i,
    output logic          busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [7:0] C_DELAYS = 8'(DELAYS);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [7:0]    r_cnt;
    logic [AW-1:0] r_adr;
    logic [31:0]   r_dat;
    logic [3:0]    r_we;
    logic          r_is_wr;
    logic          r_err;
    logic          r_sup;

    logic          w_req;
    logic          w_accept;
    logic          w_addr_ok;
    logic          w_unused_adr;

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_accept = (r_state == S_IDLE) && w_req;

`ifdef WB_EXMEM_ADDR_CHECK_EN
    assign w_addr_ok = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
`else
    // Upper address bits alias onto the BRAM window.
    assign w_addr_ok = 1'b1;
`endif

    assign w_unused_adr = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!w_addr_ok) begin
                        w_next = S_ACK;
                    end else if (C_DELAYS != 8'd0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_MEM;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt <= 8'd1) begin
                    w_next = S_MEM;
                end
            end
            S_MEM:   w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latches, wait-state counter and ack suppression flag
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt   <= 8'd0;
            r_adr   <= '0;
            r_dat   <= 32'd0;
            r_we    <= 4'd0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
            r_sup   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err <= !w_addr_ok;
                r_sup <= 1'b0;
                r_cnt <= C_DELAYS;
                if (w_addr_ok) begin
                    r_adr   <= wbs_adr_i[AW+1:2];
                    r_dat   <= wbs_dat_i;
                    r_we    <= wbs_sel_i & {4{wbs_we_i}};
                    r_is_wr <= wbs_we_i;
                end
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 8'd1;
            end
            // A master that leaves during MEM still gets its access but no ack.
            if ((r_state == S_MEM) && !wbs_cyc_i) begin
                r_sup <= 1'b1;
            end
        end
    end

    // Output decode
    always_comb begin
        bram_en_o  = (r_state == S_MEM);
        bram_we_o  = (r_state == S_MEM) ? r_we : 4'd0;
        bram_adr_o = r_adr;
        bram_di_o  = r_dat;
        wbs_ack_o  = (r_state == S_ACK) && wbs_cyc_i && !r_sup;
        wbs_dat_o  = (wbs_ack_o && !r_is_wr && !r_err) ? bram_do_i : 32'd0;
        busy_o     = (r_state != S_IDLE);
    end

endmodule
`default_nettype wire
